// File: rtl/exhaust_display.sv
// ---------------------------------------------------------------------------
// exhaust_display
//   Four-digit multiplexed 7-segment driver for the range-hood controller.
//   Digit 3 (leftmost) shows the exhaust mode ('S' while selecting a mode)
//   with the decimal point lit while the fan is busy; digits 2..0 show the
//   countdown in decimal with leading-zero blanking.  The binary countdown
//   is converted to BCD by a sequential shift-add-3 engine.
//
// Parameters
//   SCAN_DIV  : clk cycles each digit stays enabled (>= 2)
//   BLINK_DIV : clk cycles per blink half-period (>= 2)
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   synchronous active-high reset
//   mode[1:0]        in   0 idle, 1 level1, 2 level2, 3 hurricane
//   countdown[7:0]   in   binary countdown 0..255
//   busy             in   exhaust working flag (digit 3 dp)
//   countdown_active in   show countdown digits when high
//   in_switch_mode   in   mode-selection state flag
//   seg[7:0]         out  segments a..g on bits 0..6, dp on bit 7, active-high
//   an[3:0]          out  one-hot digit enable, an[3] leftmost
//   bcd_ready        out  high when BCD registers match the latched countdown
//
// Optional feature
//   EXHAUST_DISPLAY_BLINK_EN : when defined, digit 3 blinks while
//   in_switch_mode is high.  Undefined by default.
// ---------------------------------------------------------------------------
module exhaust_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [7:0] countdown,
    input  logic       busy,
    input  logic       countdown_active,
    input  logic       in_switch_mode,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       bcd_ready
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_SHIFT,
        CV_DONE
    } cv_state_t;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    seg_pattern = 7'h3F;
            4'd1:    seg_pattern = 7'h06;
            4'd2:    seg_pattern = 7'h5B;
            4'd3:    seg_pattern = 7'h4F;
            4'd4:    seg_pattern = 7'h66;
            4'd5:    seg_pattern = 7'h6D;
            4'd6:    seg_pattern = 7'h7D;
            4'd7:    seg_pattern = 7'h07;
            4'd8:    seg_pattern = 7'h7F;
            4'd9:    seg_pattern = 7'h6F;
            default: seg_pattern = 7'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Binary -> BCD converter
    // ------------------------------------------------------------------
    cv_state_t   cv_state_q, cv_state_d;
    logic [7:0]  last_bin_q, last_bin_d;
    logic [7:0]  bin_sh_q, bin_sh_d;
    logic [11:0] bcd_sh_q, bcd_sh_d;
    logic [2:0]  iter_q, iter_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic        bcd_ready_q, bcd_ready_d;
    logic [11:0] adj;

    always_comb begin
        cv_state_d  = cv_state_q;
        last_bin_d  = last_bin_q;
        bin_sh_d    = bin_sh_q;
        bcd_sh_d    = bcd_sh_q;
        iter_d      = iter_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        bcd_ready_d = 1'b0;

        // Add 3 to every BCD nibble >= 5 before the shift
        adj = bcd_sh_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_sh_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd_sh_q[i*4 +: 4] + 4'd3;
        end

        case (cv_state_q)
            CV_IDLE: begin
                // Ready only while idle with nothing new to convert, so it
                // drops in the same cycle a change is picked up.
                bcd_ready_d = (countdown == last_bin_q);
                if (countdown != last_bin_q) begin
                    last_bin_d = countdown;
                    bin_sh_d   = countdown;
                    bcd_sh_d   = '0;
                    iter_d     = '0;
                    cv_state_d = CV_SHIFT;
                end
            end
            CV_SHIFT: begin
                bcd_sh_d = {adj[10:0], bin_sh_q[7]};
                bin_sh_d = {bin_sh_q[6:0], 1'b0};
                iter_d   = iter_q + 3'd1;
                if (iter_q == 3'd7)
                    cv_state_d = CV_DONE;
            end
            CV_DONE: begin
                hund_d     = bcd_sh_q[11:8];
                tens_d     = bcd_sh_q[7:4];
                ones_d     = bcd_sh_q[3:0];
                cv_state_d = CV_IDLE;
            end
            default: cv_state_d = CV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cv_state_q  <= CV_IDLE;
            last_bin_q  <= '0;
            bin_sh_q    <= '0;
            bcd_sh_q    <= '0;
            iter_q      <= '0;
            hund_q      <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            bcd_ready_q <= 1'b1;
        end else begin
            cv_state_q  <= cv_state_d;
            last_bin_q  <= last_bin_d;
            bin_sh_q    <= bin_sh_d;
            bcd_sh_q    <= bcd_sh_d;
            iter_q      <= iter_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            bcd_ready_q <= bcd_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional blink timebase for digit 3
    // ------------------------------------------------------------------
`ifdef EXHAUST_DISPLAY_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_on_d  = blink_on_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Digit scan and segment selection
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        index_q, index_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        index_d    = index_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            index_d    = index_q + 2'd1;
        end

        // an and seg are both derived from the next index so they change
        // together in the same cycle.
        an_d  = 4'b0001 << index_d;
        seg_d = '0;
        case (index_d)
            2'd3: begin
                seg_d = {busy, in_switch_mode ? 7'h6D : seg_pattern({2'b00, mode})};
`ifdef EXHAUST_DISPLAY_BLINK_EN
                if (in_switch_mode && !blink_on_q)
                    seg_d = '0;
`endif
            end
            2'd2: if (countdown_active && hund_q != 4'd0)
                      seg_d = {1'b0, seg_pattern(hund_q)};
            2'd1: if (countdown_active && (hund_q != 4'd0 || tens_q != 4'd0))
                      seg_d = {1'b0, seg_pattern(tens_q)};
            default: if (countdown_active)
                      seg_d = {1'b0, seg_pattern(ones_q)};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
            index_q    <= '0;
            seg_q      <= '0;
            an_q       <= 4'b0001;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            index_q    <= index_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign bcd_ready = bcd_ready_q;

endmodule
